fir_decim_avg: RTL and testbench
================================

// Module: fir_decim_avg
// PURPOSE
//  Accumulate-and-dump decimator directly downstream of fir_top. Consumes the FIR
//  output stream (16-bit signed, valid/ready), sums 2**DECIM_LOG2 consecutive samples,
//  and emits one rounded average per frame on a registered valid/ready output.
//  Provides sample-rate reduction plus boxcar anti-alias smoothing for the next stage.
// PARAMETERS
//  DATA_W      16  sample width, two's complement, in and out
//  DECIM_LOG2  2   log2 of decimation factor M; legal 0..8; 0 = passthrough (M=1)
// PORTS
//  clk      in   1        system clock, all logic on rising edge
//  rst_n    in   1        asynchronous active-low reset
//  i_data   in   DATA_W   sample from fir_top o_data (signed)
//  i_valid  in   1        sample valid (from fir_top o_valid)
//  o_ready  out  1        this block can accept i_data (to fir_top i_ready)
//  i_clear  in   1        sync clear: drop partial frame, restart phase at 0
//  o_data   out  DATA_W   decimated average (signed), registered
//  o_valid  out  1        o_data valid, registered
//  i_ready  in   1        downstream ready for o_data
// BEHAVIOUR
//  Reset (async assert, sync release): acc=0, phase=0, o_data=0, o_valid=0; o_ready=1.
//  Handshake: input accepted on cycle with i_valid && o_ready; output transfer on
//   o_valid && i_ready. o_ready = !o_valid || i_ready (comb from i_ready, no other path).
//   While o_valid=1 and i_ready=0: o_ready=0, no input accepted, o_data/o_valid stable.
//  o_valid clears on transfer unless a new result is produced the same cycle.
//  Accumulator: ACC_W = DATA_W+DECIM_LOG2, signed, sign-extend every input; cannot
//   overflow. phase counter DECIM_LOG2 bits (1 bit min), counts accepted samples.
//  Accepted sample with phase<M-1: acc += sample; phase++.
//  Accepted sample with phase==M-1 (frame end): sum = acc + sample;
//   o_data <= (sum + (DECIM_LOG2>0 ? 2**(DECIM_LOG2-1) : 0)) >>> DECIM_LOG2 (round half
//   up, arithmetic shift); o_valid<=1; acc<=0; phase<=0. Result fits DATA_W by range:
//   max 2**(DATA_W-1)-1, min -2**(DATA_W-1); no saturation logic.
//  Latency: o_valid rises cycle after frame-end sample accepted (1 clk).
//  Back-to-back: with i_ready=1 continuous, one sample/clk accepted, no bubbles;
//   DECIM_LOG2=0 gives full-throughput 1-clk registered passthrough.
//  Phase wrap: phase returns to 0 only at frame end or i_clear; never exceeds M-1.
//  i_clear: acc<=0, phase<=0 next edge; input sample in same cycle is discarded
//   (o_ready unaffected, handshake still completes). o_data/o_valid untouched: a held
//   result still drains. i_clear with frame-end sample same cycle: no result produced.
//  Simultaneous output transfer + frame-end input: o_data updated, o_valid stays 1.
//  Reset mid-frame: partial sum and held output lost; o_valid=0 immediately (async).
//  No X on outputs after reset regardless of i_data X while i_valid=0.
// TESTING (DECIM_LOG2=2 unless noted; i_ready=1 unless noted)
//  1. Samples 1,2,3,4 -> single output 3 (10+2>>2), o_valid 1 clk after 4th accept.
//  2. Samples -1,-1,-1,-2 -> output -1 (-5+2=-3 >>>2); 32767 x4 -> 32767; -32768 x4
//     -> -32768; mixed 32767,-32768,0,0 -> 0 (-1+2>>2).
//  3. Backpressure: complete frame, hold i_ready=0 8 clks -> o_data stable, o_ready=0,
//     upstream stalls; release -> transfer, next frame sums resume with no lost sample.
//  4. Streaming 1..16, i_valid=1 every clk -> outputs 3,7,11,15 (2.5->3 etc.), no bubbles.
//  5. i_clear after 2 samples (5,5) then 4,4,4,4 -> output 4; clear while output held ->
//     held value still delivered.
//  6. DECIM_LOG2=0: 100,-7,0 -> 100,-7,0 at 1 clk latency; async reset mid-frame -> all
//     outputs 0 without clock, next frame starts phase 0.

Source files
------------

// File: rtl/fir_decim_avg.sv
// Accumulate-and-dump decimator: sums 2**DECIM_LOG2 samples and emits a round-half-up average.
// Latency: result registered, o_valid rises 1 clk after the frame-end sample is accepted.
// Backpressure: o_ready = !o_valid || i_ready; a held result stalls upstream until it drains.
//
// Ports:
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   i_data/i_valid    signed input sample stream from the FIR
//   o_ready           input accepted when i_valid && o_ready
//   i_clear           synchronous clear of the partial frame (held output unaffected)
//   o_data/o_valid    registered signed average, transferred when o_valid && i_ready
//   i_ready           downstream ready
module fir_decim_avg #(
  parameter int DATA_W     = 16,
  parameter int DECIM_LOG2 = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic signed [DATA_W-1:0] i_data,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic                     i_clear,
  output logic signed [DATA_W-1:0] o_data,
  output logic                     o_valid,
  input  logic                     i_ready
);

  // Accumulator is wide enough for M full-scale samples, so it never overflows.
  localparam int ACC_W = DATA_W + DECIM_LOG2;
  // Phase counter keeps at least one bit so the M=1 build stays well formed.
  localparam int PH_W  = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'((1 << DECIM_LOG2) - 1);
  // Half an LSB of the output for round-half-up; zero in passthrough mode.
  localparam logic signed [ACC_W-1:0] RND = ACC_W'((1 << DECIM_LOG2) >> 1);

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W-1:0] sum_rnd;
  logic [PH_W-1:0]         phase;
  logic                    accept;
  logic                    frame_end;
  logic                    produce;

  assign o_ready   = !o_valid || i_ready;
  assign accept    = i_valid && o_ready;
  assign frame_end = (phase == PH_LAST);
  // A clear in the frame-end cycle discards the sample and the frame with it.
  assign produce   = accept && frame_end && !i_clear;

  assign sum     = acc + ACC_W'(i_data);
  assign sum_rnd = sum + RND;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      phase   <= '0;
      o_data  <= '0;
      o_valid <= 1'b0;
    end else begin
      if (o_valid && i_ready) begin
        o_valid <= 1'b0;
      end
      // A new result in the same cycle as a transfer keeps o_valid high.
      if (produce) begin
        // The arithmetic-shifted rounded sum always lies in the DATA_W range.
        o_data  <= DATA_W'(sum_rnd >>> DECIM_LOG2);
        o_valid <= 1'b1;
      end

      if (i_clear) begin
        acc   <= '0;
        phase <= '0;
      end else if (accept) begin
        if (frame_end) begin
          acc   <= '0;
          phase <= '0;
        end else begin
          acc   <= sum;
          phase <= phase + PH_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_fir_decim_avg.sv
// Bench for fir_decim_avg: DUT a with M=4, DUT b with M=1 (passthrough).
// A frame-level model predicts every result; a compare process checks outputs each cycle.
// Directed tests add literal expectations on the delivered result sequence.
module tb_fir_decim_avg;

  localparam int DW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic signed [DW-1:0] i_data_a, o_data_a, i_data_b, o_data_b;
  logic i_valid_a, o_ready_a, i_clear_a, o_valid_a, i_ready_a;
  logic i_valid_b, o_ready_b, i_clear_b, o_valid_b, i_ready_b;

  fir_decim_avg #(.DATA_W(DW), .DECIM_LOG2(2)) u_a (
    .clk(clk), .rst_n(rst_n),
    .i_data(i_data_a), .i_valid(i_valid_a), .o_ready(o_ready_a), .i_clear(i_clear_a),
    .o_data(o_data_a), .o_valid(o_valid_a), .i_ready(i_ready_a)
  );

  fir_decim_avg #(.DATA_W(DW), .DECIM_LOG2(0)) u_b (
    .clk(clk), .rst_n(rst_n),
    .i_data(i_data_b), .i_valid(i_valid_b), .o_ready(o_ready_b), .i_clear(i_clear_b),
    .o_data(o_data_b), .o_valid(o_valid_b), .i_ready(i_ready_b)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name, input int act, input int exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Average of m samples rounded half up: floor((sum + m/2) / m).
  function automatic int frame_avg(input int q[$], input int m);
    int s;
    int num;
    int quo;
    s = 0;
    foreach (q[k]) s += q[k];
    num = s + m / 2;
    quo = num / m;
    if ((num % m) != 0 && num < 0) quo -= 1;
    return quo;
  endfunction

  // ---------------- model ----------------
  int part_a[$], exp_a[$], seen_a[$];
  int part_b[$], exp_b[$], seen_b[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      part_a.delete(); exp_a.delete();
      part_b.delete(); exp_b.delete();
    end else begin
      if (i_clear_a) part_a.delete();
      else if (i_valid_a && o_ready_a) begin
        part_a.push_back(int'(i_data_a));
        if (part_a.size() == 4) begin
          exp_a.push_back(frame_avg(part_a, 4));
          part_a.delete();
        end
      end
      if (i_clear_b) part_b.delete();
      else if (i_valid_b && o_ready_b) begin
        part_b.push_back(int'(i_data_b));
        exp_b.push_back(frame_avg(part_b, 1));
        part_b.delete();
      end
    end
  end

  // ---------------- compare ----------------
  logic prev_stall_a = 1'b0, prev_stall_b = 1'b0;
  int   prev_dat_a = 0, prev_dat_b = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      chk(o_ready_a === (!o_valid_a || i_ready_a), "a_ready_rule", o_ready_a, !o_valid_a || i_ready_a);
      chk(o_valid_a === (exp_a.size() > 0), "a_valid", o_valid_a, exp_a.size() > 0);
      if (o_valid_a === 1'b1 && exp_a.size() > 0)
        chk(int'(o_data_a) == exp_a[0], "a_data", o_data_a, exp_a[0]);
      if (prev_stall_a)
        chk(o_valid_a === 1'b1 && int'(o_data_a) == prev_dat_a, "a_stall_hold", o_data_a, prev_dat_a);
      prev_stall_a <= o_valid_a && !i_ready_a;
      prev_dat_a   <= int'(o_data_a);
      if (o_valid_a && i_ready_a) begin
        seen_a.push_back(int'(o_data_a));
        if (exp_a.size() > 0) void'(exp_a.pop_front());
      end

      chk(o_ready_b === (!o_valid_b || i_ready_b), "b_ready_rule", o_ready_b, !o_valid_b || i_ready_b);
      chk(o_valid_b === (exp_b.size() > 0), "b_valid", o_valid_b, exp_b.size() > 0);
      if (o_valid_b === 1'b1 && exp_b.size() > 0)
        chk(int'(o_data_b) == exp_b[0], "b_data", o_data_b, exp_b[0]);
      if (prev_stall_b)
        chk(o_valid_b === 1'b1 && int'(o_data_b) == prev_dat_b, "b_stall_hold", o_data_b, prev_dat_b);
      prev_stall_b <= o_valid_b && !i_ready_b;
      prev_dat_b   <= int'(o_data_b);
      if (o_valid_b && i_ready_b) begin
        seen_b.push_back(int'(o_data_b));
        if (exp_b.size() > 0) void'(exp_b.pop_front());
      end
    end else begin
      prev_stall_a <= 1'b0;
      prev_stall_b <= 1'b0;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present one sample and return 1 ns after the edge that accepted it.
  task automatic send(input bit sel, input int v);
    int n;
    n = 0;
    if (sel) begin i_valid_b = 1'b1; i_data_b = DW'(v); end
    else     begin i_valid_a = 1'b1; i_data_a = DW'(v); end
    @(negedge clk);
    while (!(sel ? o_ready_b : o_ready_a) && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (n >= 100) chk((sel ? o_ready_b : o_ready_a) === 1'b1, "send_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic check_seen(input bit sel, input string nm, input int e[$]);
    int got[$];
    if (sel) got = seen_b;
    else     got = seen_a;
    chk(got.size() == e.size(), {nm, "_count"}, got.size(), e.size());
    for (int i = 0; i < e.size() && i < got.size(); i++)
      chk(got[i] == e[i], nm, got[i], e[i]);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk(o_valid_a === 1'b0 && o_data_a === 16'sd0 && o_ready_a === 1'b1, "rst_async_a", o_data_a, 0);
    chk(o_valid_b === 1'b0 && o_data_b === 16'sd0 && o_ready_b === 1'b1, "rst_async_b", o_data_b, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- directed tests ----------------
  initial begin
    int e[$];
    int t0;
    int t2[16];
    rst_n = 1'b1;
    i_valid_a = 1'b0; i_clear_a = 1'b0; i_ready_a = 1'b1; i_data_a = 'x;
    i_valid_b = 1'b0; i_clear_b = 1'b0; i_ready_b = 1'b1; i_data_b = 'x;
    #2 rst_n = 1'b0;
    #1;
    chk(o_valid_a === 1'b0 && o_data_a === 16'sd0, "reset_a", o_data_a, 0);
    chk(o_ready_a === 1'b1, "reset_ready_a", o_ready_a, 1);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    idle(3);
    @(negedge clk);
    chk(o_valid_a === 1'b0 && o_data_a === 16'sd0, "post_reset_a_no_x", o_data_a, 0);
    chk(o_valid_b === 1'b0 && o_data_b === 16'sd0, "post_reset_b_no_x", o_data_b, 0);
    idle(1);

    // 1: 1,2,3,4 -> 3, valid one clock after the 4th accept
    seen_a.delete();
    for (int i = 1; i <= 4; i++) send(1'b0, i);
    i_valid_a = 1'b0;
    @(negedge clk);
    chk(o_valid_a === 1'b1 && o_data_a == 16'sd3, "t1_latency", o_data_a, 3);
    idle(3);
    e = '{3};
    check_seen(1'b0, "t1_seen", e);

    // 2: rounding and range extremes
    seen_a.delete();
    t2 = '{-1, -1, -1, -2, 32767, 32767, 32767, 32767,
           -32768, -32768, -32768, -32768, 32767, -32768, 0, 0};
    foreach (t2[i]) send(1'b0, t2[i]);
    i_valid_a = 1'b0;
    idle(3);
    e = '{-1, 32767, -32768, 0};
    check_seen(1'b0, "t2_seen", e);

    // 3: backpressure with an upstream sample waiting
    seen_a.delete();
    i_ready_a = 1'b0;
    for (int i = 1; i <= 4; i++) send(1'b0, i);
    i_valid_a = 1'b1; i_data_a = 16'sd5;
    repeat (8) begin
      @(negedge clk);
      chk(o_ready_a === 1'b0 && o_valid_a === 1'b1 && o_data_a == 16'sd3, "t3_stall", o_data_a, 3);
    end
    @(posedge clk); #1;
    i_ready_a = 1'b1;
    @(posedge clk); #1;
    for (int i = 6; i <= 8; i++) send(1'b0, i);
    i_valid_a = 1'b0;
    idle(3);
    e = '{3, 7};
    check_seen(1'b0, "t3_seen", e);

    // 4: streaming 1..16 with no bubbles
    seen_a.delete();
    t0 = cyc;
    for (int i = 1; i <= 16; i++) send(1'b0, i);
    chk(cyc - t0 == 16, "t4_no_bubbles", cyc - t0, 16);
    i_valid_a = 1'b0;
    idle(3);
    e = '{3, 7, 11, 15};
    check_seen(1'b0, "t4_seen", e);

    // 5: clear behaviour
    seen_a.delete();
    send(1'b0, 5); send(1'b0, 5);
    i_clear_a = 1'b1; send(1'b0, 9); i_clear_a = 1'b0;
    for (int i = 0; i < 4; i++) send(1'b0, 4);
    send(1'b0, 1); send(1'b0, 1); send(1'b0, 1);
    i_clear_a = 1'b1; send(1'b0, 1); i_clear_a = 1'b0;
    i_valid_a = 1'b0;
    idle(3);
    @(negedge clk);
    chk(o_valid_a === 1'b0, "t5_clear_frame_end", o_valid_a, 0);
    @(posedge clk); #1;
    i_ready_a = 1'b0;
    for (int i = 0; i < 4; i++) send(1'b0, 8);
    i_valid_a = 1'b0;
    i_clear_a = 1'b1;
    @(posedge clk); #1;
    i_clear_a = 1'b0;
    idle(2);
    @(negedge clk);
    chk(o_valid_a === 1'b1 && o_data_a == 16'sd8, "t5_held_after_clear", o_data_a, 8);
    @(posedge clk); #1;
    i_ready_a = 1'b1;
    idle(3);
    e = '{4, 8};
    check_seen(1'b0, "t5_seen", e);

    // 6a: passthrough on the M=1 instance
    seen_b.delete();
    send(1'b1, 100);
    i_valid_b = 1'b0;
    @(negedge clk);
    chk(o_valid_b === 1'b1 && o_data_b == 16'sd100, "t6_latency", o_data_b, 100);
    @(posedge clk); #1;
    t0 = cyc;
    send(1'b1, -7); send(1'b1, 0); send(1'b1, 32767); send(1'b1, -32768);
    chk(cyc - t0 == 4, "t6_no_bubbles", cyc - t0, 4);
    i_valid_b = 1'b0;
    idle(3);
    e = '{100, -7, 0, 32767, -32768};
    check_seen(1'b1, "t6_seen", e);

    // 6b: async reset with held outputs, then with a partial frame
    i_ready_a = 1'b0; i_ready_b = 1'b0;
    for (int i = 1; i <= 4; i++) send(1'b0, i);
    i_valid_a = 1'b0;
    send(1'b1, 100);
    i_valid_b = 1'b0;
    @(negedge clk);
    chk(o_valid_a === 1'b1 && o_valid_b === 1'b1, "t6_held_before_reset", o_valid_a, 1);
    i_ready_a = 1'b1; i_ready_b = 1'b1;
    pulse_reset();
    seen_a.delete();
    send(1'b0, 6); send(1'b0, 6);
    i_valid_a = 1'b0;
    pulse_reset();
    for (int i = 0; i < 4; i++) send(1'b0, 4);
    i_valid_a = 1'b0;
    idle(3);
    e = '{4};
    check_seen(1'b0, "t6_after_reset", e);

    chk(exp_a.size() == 0 && exp_b.size() == 0, "drain", exp_a.size() + exp_b.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
